// File: rtl/sr_sw_ram_arb_pkg.sv
// Shared helpers for the single-read/single-write RAM arbiter.
// Holds the one-hot-to-index function and the response reset value.
package sr_sw_ram_arb_pkg;

  localparam int MAX_REQ    = 32;
  localparam int RESET_DATA = 0;

  function automatic int oh2idx(input logic [MAX_REQ-1:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: scans from ptr upward, first valid wins.
// Ports: clk, rst_n, valid[NUM_REQ] in, one-hot grant[NUM_REQ] out.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] valid,
  output logic [NUM_REQ-1:0] grant
);

  logic [IW-1:0] ptr;
  logic [IW-1:0] ptr_nxt;
  logic          hit;
  int            j;

  always_comb begin
    grant   = '0;
    ptr_nxt = ptr;
    hit     = 1'b0;
    j       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!hit && valid[IW'(j)]) begin
        hit            = 1'b1;
        grant[IW'(j)]  = 1'b1;
        ptr_nxt        = (j == NUM_REQ - 1) ? '0 : IW'(j + 1);
      end
    end
    if (!rst_n) begin
      grant   = '0;
      ptr_nxt = ptr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr <= '0;
    else        ptr <= ptr_nxt;
  end

endmodule

// File: rtl/sr_sw_ram_arbiter.sv
// Shares one 1R/1W RAM between NUM_REQ clients; independent RR per port.
// Ports: wr/rd valid+addr(+data) in, one-hot ready out, registered
// one-hot rd_resp_valid + rd_resp_data, combinational ram_* drive.
// Macro SR_SW_RAM_ARB_BYPASS_EN: same-address write-to-read forwarding.
module sr_sw_ram_arbiter
  import sr_sw_ram_arb_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int DATA_WIDTH    = 8,
  parameter int DEPTH         = 4,
  parameter int ADDRESS_WIDTH = $clog2(DEPTH),
  parameter int ID_WIDTH      = $clog2(NUM_REQ)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               wr_valid,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] wr_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    wr_data,
  output logic [NUM_REQ-1:0]               wr_ready,
  input  logic [NUM_REQ-1:0]               rd_valid,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] rd_addr,
  output logic [NUM_REQ-1:0]               rd_ready,
  output logic [NUM_REQ-1:0]               rd_resp_valid,
  output logic [DATA_WIDTH-1:0]            rd_resp_data,
  output logic                             ram_chip_select,
  output logic                             ram_write_enable,
  output logic [ADDRESS_WIDTH-1:0]         ram_write_addr,
  output logic [DATA_WIDTH-1:0]            ram_write_data,
  output logic                             ram_read_enable,
  output logic [ADDRESS_WIDTH-1:0]         ram_read_addr,
  input  logic [DATA_WIDTH-1:0]            ram_read_data
);

  logic [NUM_REQ-1:0]       wgnt;
  logic [NUM_REQ-1:0]       rgnt;
  logic [ID_WIDTH-1:0]      widx;
  logic [ID_WIDTH-1:0]      ridx;
  logic [ADDRESS_WIDTH-1:0] wa [NUM_REQ];
  logic [ADDRESS_WIDTH-1:0] ra [NUM_REQ];
  logic [DATA_WIDTH-1:0]    wd [NUM_REQ];
  logic [DATA_WIDTH-1:0]    resp_nxt;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign wa[i] = wr_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign ra[i] = rd_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign wd[i] = wr_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_wr_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .valid (wr_valid),
    .grant (wgnt)
  );

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rd_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .valid (rd_valid),
    .grant (rgnt)
  );

  assign widx = ID_WIDTH'(oh2idx(MAX_REQ'(wgnt)));
  assign ridx = ID_WIDTH'(oh2idx(MAX_REQ'(rgnt)));

  assign wr_ready         = wgnt;
  assign rd_ready         = rgnt;
  assign ram_write_enable = |wgnt;
  assign ram_read_enable  = |rgnt;
  assign ram_chip_select  = ram_write_enable | ram_read_enable;
  assign ram_write_addr   = ram_write_enable ? wa[widx] : '0;
  assign ram_write_data   = ram_write_enable ? wd[widx] : '0;
  assign ram_read_addr    = ram_read_enable  ? ra[ridx] : '0;

  // The write lands at the clock edge, so the RAM read path sees the
  // old word; forwarding swaps in the word being written.
  always_comb begin
    resp_nxt = ram_read_data;
`ifdef SR_SW_RAM_ARB_BYPASS_EN
    if (ram_write_enable && ram_write_addr == ram_read_addr)
      resp_nxt = ram_write_data;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_resp_valid <= '0;
      rd_resp_data  <= DATA_WIDTH'(RESET_DATA);
    end else begin
      rd_resp_valid <= rgnt;
      if (ram_read_enable) rd_resp_data <= resp_nxt;
    end
  end

endmodule

// File: doc/sr_sw_ram_arbiter.md
Name: sr_sw_ram_arbiter

Overview:
- Shares one single-read/single-write behavioural RAM between NUM_REQ requesters.
- Write and read ports are arbitrated independently, each by its own round-robin arbiter; at most one write and one read are granted per cycle.
- Read data returns one cycle after grant, registered, tagged to the granted requester.
- Sits between client engines and the RAM instance; owns the RAM's enables, addresses and chip select.

Parameters:
- NUM_REQ, 4, number of requesters (>=2)
- DATA_WIDTH, 8, RAM word width
- DEPTH, 4, RAM words
- ADDRESS_WIDTH, $clog2(DEPTH), RAM address width
- ID_WIDTH, $clog2(NUM_REQ), requester index width

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- wr_valid  in  NUM_REQ  per-requester write request
- wr_addr  in  NUM_REQ*ADDRESS_WIDTH  packed write addresses, requester i at slice i
- wr_data  in  NUM_REQ*DATA_WIDTH  packed write data
- wr_ready  out  NUM_REQ  one-hot write grant, combinational
- rd_valid  in  NUM_REQ  per-requester read request
- rd_addr  in  NUM_REQ*ADDRESS_WIDTH  packed read addresses
- rd_ready  out  NUM_REQ  one-hot read grant, combinational
- rd_resp_valid  out  NUM_REQ  one-hot, registered read response strobe
- rd_resp_data  out  DATA_WIDTH  registered read data, shared by all requesters
- ram_chip_select  out  1  high when any grant is active
- ram_write_enable  out  1  write grant active
- ram_write_addr  out  ADDRESS_WIDTH  granted write address
- ram_write_data  out  DATA_WIDTH  granted write data
- ram_read_enable  out  1  read grant active
- ram_read_addr  out  ADDRESS_WIDTH  granted read address
- ram_read_data  in  DATA_WIDTH  RAM asynchronous read data

Behaviour:
- Reset (rst_n low, asynchronous):
  - wr_ptr = 0, rd_ptr = 0.
  - rd_resp_valid = 0, rd_resp_data = 0.
  - Grants are forced 0 while rst_n is low.
- Handshake: a transfer occurs when valid[i] && ready[i].
  - A requester holds valid, address and data stable until ready.
  - ready never depends on the requester's own ready.
- Round-robin grant per port:
  - Scan from ptr upward, modulo NUM_REQ; the first asserted valid wins.
  - On a grant to index g, ptr <= (g+1) mod NUM_REQ.
  - No grant leaves ptr unchanged.
  - Wrap: g = NUM_REQ-1 sets ptr to 0.
- RAM drive: RAM outputs are combinational muxes of the granted slice.
  - Enables equal OR of the grants.
  - ram_chip_select = ram_write_enable | ram_read_enable.
  - With no grant, addresses and data drive 0.
- Read latency is 1 cycle.
  - On a read grant to g: rd_resp_valid <= onehot(g), rd_resp_data <= ram_read_data.
  - Otherwise rd_resp_valid <= 0 and rd_resp_data holds.
- Back-to-back reads from the same requester are allowed every cycle when it is alone; the response stream is pipelined.
- Simultaneous read and write to the same address: the read returns the OLD word, because the write lands at the clock edge.
- Ports are independent: a read grant never blocks a write grant and vice versa.
- Reset asserted mid-transfer: a pending response is dropped (rd_resp_valid cleared); RAM contents are not touched.
- Starvation bound: a continuously valid requester is granted within NUM_REQ cycles.

Optional Feature:
- Macro: SR_SW_RAM_ARB_BYPASS_EN
- Defined: when the write grant and read grant are active in the same cycle with equal addresses, rd_resp_data <= ram_write_data, i.e. the NEW word (write-to-read forwarding).
- Undefined: the old word is returned, as stated above.
- Both builds: grant, pointer and timing behaviour are identical.

Decomposition:
- Package sr_sw_ram_arb_pkg: localparam helpers for the onehot-to-index function and a reset-data constant.
  - Keep widths parameterised in the module, not in the package.
- Sub-module rr_arbiter (NUM_REQ parameter): valid vector in, one-hot grant out, owns its pointer with async active-low reset.
  - Instantiated twice, once for the write port and once for the read port.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, all valids 0 -> every output 0, ram_chip_select=0 for 10 cycles.
- Write sweep: requester 2 writes addr 0..3 data 8'hA0..8'hA3, then requester 0 reads addr 0..3 -> rd_resp_valid=4'b0001 one cycle after each grant, data A0,A1,A2,A3.
- Round-robin fairness: all four rd_valid held high for 8 cycles, ptr at reset -> grants 0,1,2,3,0,1,2,3 and each rd_resp_valid lags its grant by 1.
- Wrap and skip: only requesters 3 and 1 valid, ptr=2 -> grant 3, then 1, then 3.
- Same-address collision: addr 1 holds 8'h11; write 8'h55 and read addr 1 in the same cycle -> response 8'h11 without the macro, 8'h55 with SR_SW_RAM_ARB_BYPASS_EN; the next read of addr 1 returns 8'h55 in both builds.
- Mid-operation reset: read granted, rst_n dropped before the next edge -> rd_resp_valid stays 0 and ptrs return to 0; a later read of previously written data still returns the stored value.
